// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port superRam.
// One access is outstanding at a time; writes take IDLE->ACCESS->IDLE,
// reads take IDLE->ACCESS->WAIT->DONE->IDLE and return masked data on rdata.
module ram_arbiter (
   input  logic        clk,
   input  logic        nRst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [7:0]  addr0,
   input  logic [7:0]  addr1,
   input  logic [2:0]  spam0,
   input  logic [2:0]  spam1,
   input  logic [63:0] wdata0,
   input  logic [63:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [63:0] rdata,
   output logic        busy,
   output logic [7:0]  ramAddress,
   output logic [2:0]  ramSpam,
   output logic [63:0] ramDataIn,
   output logic        ramWren,
   input  logic [63:0] ramDataOut
);

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned SPAM_W  = 3;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned N_BYTES = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                winner_q, winner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [SPAM_W-1:0]   spam_q, spam_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                gnt0_q, gnt0_d;
   logic                gnt1_q, gnt1_d;
   logic                rvalid0_q, rvalid0_d;
   logic                rvalid1_q, rvalid1_d;
   logic                busy_q, busy_d;
   logic                wren_q, wren_d;
   logic                pick_c;

   // Zero every byte above the highest active byte index; byte 0 always passes.
   function automatic logic [DATA_W-1:0] byte_mask(input logic [DATA_W-1:0] d,
                                                   input logic [SPAM_W-1:0] spam);
      logic [DATA_W-1:0] m;
      m = d;
      for (int k = 0; k < int'(N_BYTES); k++) begin
         if (SPAM_W'(k) > spam) m[8*k +: 8] = 8'h00;
      end
      return m;
   endfunction

   // Round-robin winner: a lone request wins, a tie goes to the one not granted last.
   assign pick_c = (req0 && req1) ? ~last_grant_q : req1;

   // Next-state, latching and output decode.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      winner_d     = winner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      spam_d       = spam_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      gnt0_d       = 1'b0;
      gnt1_d       = 1'b0;
      rvalid0_d    = 1'b0;
      rvalid1_d    = 1'b0;
      wren_d       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               winner_d     = pick_c;
               last_grant_d = pick_c;
               we_d         = pick_c ? we1   : we0;
               addr_d       = pick_c ? addr1 : addr0;
               spam_d       = pick_c ? spam1 : spam0;
               wdata_d      = pick_c ? byte_mask(wdata1, spam1) : byte_mask(wdata0, spam0);
               gnt0_d       = ~pick_c;
               gnt1_d       = pick_c;
               wren_d       = pick_c ? we1 : we0;
               state_d      = S_ACCESS;
            end
         end
         S_ACCESS: state_d = we_q ? S_IDLE : S_WAIT;
         S_WAIT:   state_d = S_DONE;
         S_DONE: begin
            rdata_d   = byte_mask(ramDataOut, spam_q);
            rvalid0_d = ~winner_q;
            rvalid1_d = winner_q;
            state_d   = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs; reset aborts any access in flight.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         winner_q     <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         spam_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         busy_q       <= 1'b0;
         wren_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         winner_q     <= winner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         spam_q       <= spam_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         gnt0_q       <= gnt0_d;
         gnt1_q       <= gnt1_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
         busy_q       <= busy_d;
         wren_q       <= wren_d;
      end
   end

   assign gnt0       = gnt0_q;
   assign gnt1       = gnt1_q;
   assign rvalid0    = rvalid0_q;
   assign rvalid1    = rvalid1_q;
   assign rdata      = rdata_q;
   assign busy       = busy_q;
   assign ramAddress = addr_q;
   assign ramSpam    = spam_q;
   assign ramDataIn  = wdata_q;
   assign ramWren    = wren_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a two-edge-latency superRam model.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        nRst;
   logic        req0, req1, we0, we1;
   logic [7:0]  addr0, addr1;
   logic [2:0]  spam0, spam1;
   logic [63:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, busy, ramWren;
   logic [63:0] rdata, ramDataIn, ramDataOut;
   logic [7:0]  ramAddress;
   logic [2:0]  ramSpam;

   typedef struct {
      logic        id;
      logic        we;
      logic [7:0]  addr;
      logic [2:0]  spam;
      logic [63:0] data;
   } txn_t;

   typedef struct {
      logic        id;
      logic [63:0] data;
      int          due;
   } pend_t;

   txn_t  exp_q[$];
   pend_t pend_q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   int    cyc = 0;
   int    rv_count = 0;
   logic  prev_gnt = 1'b0;

   // superRam model: address registered on one edge, data out on the next.
   logic [63:0] mem [0:255];
   logic [7:0]  ram_addr_p = 8'h00;

   ram_arbiter dut (
      .clk(clk), .nRst(nRst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .spam0(spam0), .spam1(spam1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .busy(busy),
      .ramAddress(ramAddress), .ramSpam(ramSpam), .ramDataIn(ramDataIn),
      .ramWren(ramWren), .ramDataOut(ramDataOut)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (ramWren) mem[ramAddress] <= ramDataIn;
      ram_addr_p <= ramAddress;
      ramDataOut <= mem[ram_addr_p];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expectations whenever the DUT shows gnt, ramWren or rvalid.
   always @(negedge clk) begin
      txn_t  t;
      pend_t p;
      if (!nRst) begin
         pend_q.delete();
         prev_gnt = 1'b0;
      end else begin
         if (gnt0 || gnt1) begin
            chk("gnt_excl", {63'd0, gnt0 & gnt1}, 64'd0);
            chk("gnt_pulse", {63'd0, prev_gnt}, 64'd0);
            chk("busy_access", {63'd0, busy}, 64'd1);
            if (exp_q.size() == 0) begin
               chk("unexpected_gnt", 64'd1, 64'd0);
            end else begin
               t = exp_q.pop_front();
               chk("gnt_id", {63'd0, gnt1}, {63'd0, t.id});
               chk("ram_addr", {56'd0, ramAddress}, {56'd0, t.addr});
               chk("ram_spam", {61'd0, ramSpam}, {61'd0, t.spam});
               chk("ram_wren", {63'd0, ramWren}, {63'd0, t.we});
               if (t.we) chk("ram_data_in", ramDataIn, t.data);
               else begin
                  p.id = t.id; p.data = t.data; p.due = cyc + 3;
                  pend_q.push_back(p);
               end
            end
         end else if (ramWren) begin
            chk("wren_outside_access", 64'd1, 64'd0);
         end
         if (rvalid0 || rvalid1) begin
            rv_count++;
            chk("rvalid_excl", {63'd0, rvalid0 & rvalid1}, 64'd0);
            chk("busy_rvalid", {63'd0, busy}, 64'd0);
            if (pend_q.size() == 0) begin
               chk("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
               p = pend_q.pop_front();
               chk("rvalid_id", {63'd0, rvalid1}, {63'd0, p.id});
               chk("rdata", rdata, p.data);
               chk("rvalid_latency", 64'(cyc), 64'(p.due));
            end
         end
         prev_gnt = gnt0 | gnt1;
      end
   end

   task automatic push_exp(input logic id, input logic we, input logic [7:0] addr,
                           input logic [2:0] spam, input logic [63:0] data);
      txn_t t;
      t.id = id; t.we = we; t.addr = addr; t.spam = spam; t.data = data;
      exp_q.push_back(t);
   endtask

   task automatic check_reset_outputs();
      chk("rst_gnt", {62'd0, gnt0, gnt1}, 64'd0);
      chk("rst_rvalid", {62'd0, rvalid0, rvalid1}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_wren", {63'd0, ramWren}, 64'd0);
      chk("rst_addr_spam", {53'd0, ramAddress, ramSpam}, 64'd0);
      chk("rst_data_in", ramDataIn, 64'd0);
      chk("rst_rdata", rdata, 64'd0);
   endtask

   // Drive one request, hold it until granted, then let the access drain.
   task automatic issue(input logic id, input logic we, input logic [7:0] addr,
                        input logic [2:0] spam, input logic [63:0] wdata,
                        input logic [63:0] exp_data);
      bit got;
      push_exp(id, we, addr, spam, exp_data);
      @(posedge clk); #2;
      if (id) begin req1 = 1'b1; we1 = we; addr1 = addr; spam1 = spam; wdata1 = wdata; end
      else    begin req0 = 1'b1; we0 = we; addr0 = addr; spam0 = spam; wdata0 = wdata; end
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk); #1;
         if ((id && gnt1) || (!id && gnt0)) got = 1'b1;
      end
      if (!got) chk("gnt_timeout", 64'd1, 64'd0);
      req0 = 1'b0; req1 = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      int gcyc[3];
      int ng;
      int rv_before;
      logic [63:0] bw_data [3];
      logic [2:0]  bw_spam [3];
      nRst = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; spam0 = 0; spam1 = 0; wdata0 = 0; wdata1 = 0;
      #12;
      check_reset_outputs();
      @(posedge clk); #3 nRst = 1'b1;

      // Single write, then read it back.
      issue(1'b1, 1'b1, 8'h05, 3'd5, 64'he23400789abadeff, 64'h0000_00789abadeff);
      issue(1'b0, 1'b0, 8'h05, 3'd7, 64'd0,                 64'h0000_00789abadeff);

      // Spam mask on read.
      issue(1'b0, 1'b1, 8'h20, 3'd7, 64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_ffff);
      issue(1'b1, 1'b0, 8'h20, 3'd1, 64'd0,                   64'h0000_0000_0000_ffff);

      // Back-to-back writes from requester 1.
      bw_data[0] = 64'h0123456789abcdef; bw_spam[0] = 3'd7;
      bw_data[1] = 64'hdeadbeefcafef00d; bw_spam[1] = 3'd3;
      bw_data[2] = 64'h5555aaaa5555aaaa; bw_spam[2] = 3'd0;
      push_exp(1'b1, 1'b1, 8'h40, 3'd7, 64'h0123456789abcdef);
      push_exp(1'b1, 1'b1, 8'h41, 3'd3, 64'h00000000cafef00d);
      push_exp(1'b1, 1'b1, 8'h42, 3'd0, 64'h00000000000000aa);
      @(posedge clk); #2;
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h40; spam1 = bw_spam[0]; wdata1 = bw_data[0];
      ng = 0;
      for (int i = 0; i < 40 && ng < 3; i++) begin
         @(negedge clk); #1;
         if (gnt1) begin
            gcyc[ng] = cyc;
            ng++;
            if (ng < 3) begin
               addr1 = 8'h40 + 8'(ng); spam1 = bw_spam[ng]; wdata1 = bw_data[ng];
            end
         end
      end
      req1 = 1'b0;
      chk("b2b_grants", 64'(ng), 64'd3);
      if (ng == 3) begin
         chk("b2b_gap0", 64'(gcyc[1] - gcyc[0]), 64'd2);
         chk("b2b_gap1", 64'(gcyc[2] - gcyc[1]), 64'd2);
      end
      repeat (4) @(negedge clk);
      issue(1'b0, 1'b0, 8'h42, 3'd7, 64'd0, 64'h00000000000000aa);

      // Reset while a read sits in WAIT.
      push_exp(1'b0, 1'b0, 8'h41, 3'd7, 64'h0);
      @(posedge clk); #2;
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h41; spam0 = 3'd7;
      ng = 0;
      for (int i = 0; i < 30 && ng == 0; i++) begin
         @(negedge clk); #1;
         if (gnt0) ng = 1;
      end
      req0 = 1'b0;
      chk("wait_rst_gnt", 64'(ng), 64'd1);
      @(posedge clk); #2;
      rv_before = rv_count;
      nRst = 1'b0;
      #1;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      #3 nRst = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_rvalid_after_abort", 64'(rv_count - rv_before), 64'd0);

      // Continuous tie after reset: grants alternate starting with requester 0.
      push_exp(1'b0, 1'b0, 8'h05, 3'd7, 64'h0000_00789abadeff);
      push_exp(1'b1, 1'b0, 8'h05, 3'd2, 64'h0000_0000_00badeff);
      push_exp(1'b0, 1'b0, 8'h05, 3'd7, 64'h0000_00789abadeff);
      push_exp(1'b1, 1'b0, 8'h05, 3'd2, 64'h0000_0000_00badeff);
      @(posedge clk); #2;
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05; spam0 = 3'd7;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05; spam1 = 3'd2;
      ng = 0;
      for (int i = 0; i < 60 && ng < 4; i++) begin
         @(negedge clk); #1;
         if (gnt0 || gnt1) ng++;
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("tie_grants", 64'(ng), 64'd4);
      repeat (8) @(negedge clk);

      chk("exp_left", 64'(exp_q.size()), 64'd0);
      chk("pend_left", 64'(pend_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
